// File: rtl/freq_div_cfg_ctrl_if.sv
// Divisor request channel between a configuration master and freq_div_cfg_ctrl.
// A request transfers on any rising clock edge where cfg_valid && cfg_ready.
interface freq_div_cfg_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             cfg_valid;
    logic [WIDTH-1:0] cfg_data;
    logic             cfg_ready;

    modport master (
        output cfg_valid,
        output cfg_data,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_data,
        output cfg_ready
    );
endinterface

// File: rtl/freq_div_cfg_ctrl.sv
// Configuration controller for the LED frequency-divider pipeline: changes the divisor only
// at a pattern wrap (or timeout) and resets the divider around every change.
module freq_div_cfg_ctrl #(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(5),
    parameter int unsigned      MIN_DIV     = 1,
    parameter int unsigned      RST_CYCLES  = 4,
    parameter int unsigned      TIMEOUT     = 1024
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    freq_div_cfg_ctrl_if.slave   cfg,
    input  logic                 wrap_in,
    output logic [WIDTH-1:0]     div_data,
    output logic                 div_reset_n,
    output logic                 busy,
    output logic                 applied,
    output logic                 cfg_err
);
    localparam logic [7:0]       HoldLast = 8'(RST_CYCLES - 1);
    localparam logic [15:0]      ToLast   = 16'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0] MinDiv   = WIDTH'(MIN_DIV);

    typedef enum logic [1:0] {StInit, StRun, StWaitWrap, StResync} state_e;

    state_e           state_q;
    logic [7:0]       hold_cnt_q;
    logic [15:0]      to_cnt_q;
    logic [WIDTH-1:0] pending_q;
    logic             wrap_q;

    logic handshake;
    logic wrap_edge;
    logic timed_out;
    logic hold_done;

    assign handshake = (state_q == StRun) && cfg.cfg_valid && cfg.cfg_ready;
    assign wrap_edge = wrap_q && !wrap_in;
    assign timed_out = (to_cnt_q == ToLast);
    assign hold_done = (hold_cnt_q == HoldLast);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StInit;
            hold_cnt_q    <= '0;
            to_cnt_q      <= '0;
            pending_q     <= '0;
            wrap_q        <= 1'b0;
            div_data      <= DEFAULT_DIV;
            div_reset_n   <= 1'b0;
            cfg.cfg_ready <= 1'b0;
            busy          <= 1'b1;
            applied       <= 1'b0;
            cfg_err       <= 1'b0;
        end else begin
            wrap_q  <= wrap_in;
            applied <= 1'b0;
            cfg_err <= 1'b0;
            case (state_q)
                StInit, StResync: begin
                    if (hold_done) begin
                        state_q       <= StRun;
                        hold_cnt_q    <= '0;
                        div_reset_n   <= 1'b1;
                        busy          <= 1'b0;
                        cfg.cfg_ready <= enable;
                        // Only a completed change reports; power-up restart is silent.
                        applied       <= (state_q == StResync);
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 8'd1;
                    end
                end
                StRun: begin
                    cfg.cfg_ready <= enable;
                    if (handshake) begin
                        if (cfg.cfg_data < MinDiv) begin
                            cfg_err <= 1'b1;
                        end else if (cfg.cfg_data == div_data) begin
                            applied <= 1'b1;
                        end else begin
                            pending_q     <= cfg.cfg_data;
                            to_cnt_q      <= '0;
                            state_q       <= StWaitWrap;
                            cfg.cfg_ready <= 1'b0;
                            busy          <= 1'b1;
                        end
                    end
                end
                StWaitWrap: begin
                    if (wrap_edge || timed_out) begin
                        div_data    <= pending_q;
                        div_reset_n <= 1'b0;
                        hold_cnt_q  <= '0;
                        state_q     <= StResync;
                    end else begin
                        to_cnt_q <= to_cnt_q + 16'd1;
                    end
                end
                default: state_q <= StInit;
            endcase
        end
    end
endmodule

// File: doc/freq_div_cfg_ctrl.md
Name: freq_div_cfg_ctrl

Overview:
- Configuration controller for the 8-bit LED frequency-divider pipeline (freq_div_led8_pipe).
- Owns the divider's divisor input (datain) and its active-low reset.
- Accepts new divisor values over a valid/ready handshake and applies each one only at a pattern-wrap boundary: falling edge of diode[7], or a timeout if no edge arrives.
- Resets the divider for a fixed number of cycles after every change so the LED pattern restarts cleanly.

Parameters:
- WIDTH, 8, divisor width.
- DEFAULT_DIV, 8'h05, divisor driven after reset.
- MIN_DIV, 1, smallest legal divisor; smaller requests are rejected.
- RST_CYCLES, 4, cycles div_reset_n is held low per (re)start, range 1..255.
- TIMEOUT, 1024, max cycles spent waiting for a wrap edge before forcing apply, range 1..65535.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  allows new configuration requests to be accepted.
- cfg_valid  in  1  request valid.
- cfg_data  in  WIDTH  requested divisor.
- cfg_ready  out  1  controller can accept a request this cycle.
- wrap_in  in  1  divider diode[7] (MSB of LED pattern).
- div_data  out  WIDTH  divisor to the divider's datain.
- div_reset_n  out  1  active-low reset to the divider.
- busy  out  1  high in any state other than RUN.
- applied  out  1  one-cycle pulse when a request completes.
- cfg_err  out  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset values (all registered): div_data=DEFAULT_DIV, div_reset_n=0, cfg_ready=0, busy=1, applied=0, cfg_err=0, state=INIT, hold counter=0, timeout counter=0, wrap_q=0, pending=0.
- States:
  - INIT: div_reset_n=0 for exactly RST_CYCLES cycles after reset deasserts, then go to RUN with div_reset_n=1.
  - RUN: cfg_ready = enable. A handshake occurs when cfg_valid && cfg_ready.
  - WAIT_WRAP: cfg_ready=0. The timeout counter increments each cycle.
  - RESYNC: div_reset_n=0 for exactly RST_CYCLES cycles, then go to RUN.
- Request handling, decided in the handshake cycle with the response one cycle later:
  - cfg_data < MIN_DIV: cfg_err pulses; stay in RUN; div_data unchanged.
  - cfg_data == div_data: applied pulses; stay in RUN; no divider reset.
  - Otherwise: pending <= cfg_data; timeout counter cleared; go to WAIT_WRAP.
- Wrap edge:
  - wrap_q registers wrap_in every cycle.
  - An edge is wrap_q==1 && wrap_in==0, evaluated only while in WAIT_WRAP.
  - Edges occurring in the handshake cycle are ignored.
- Apply, on an edge or when the timeout counter reaches TIMEOUT-1 (both in the same cycle counts as one apply):
  - div_data <= pending; div_reset_n <= 0; go to RESYNC.
- Completion: on leaving RESYNC, div_reset_n=1, cfg_ready=enable, and applied pulses, all in the same cycle.
- Latency:
  - Edge sampled at cycle M: div_data is updated at M+1; div_reset_n is low during M+1..M+RST_CYCLES; applied pulses at M+RST_CYCLES+1.
  - Without an edge, apply happens TIMEOUT cycles after entering WAIT_WRAP.
- enable:
  - Gates acceptance only.
  - Deasserting enable during WAIT_WRAP or RESYNC does not abort; the pending change still completes.
- cfg_valid in a non-RUN state is not accepted; the requester must hold it.
- Only one request may be outstanding; there is no queueing.
- reset at any time:
  - Discards pending and returns to INIT with DEFAULT_DIV.
  - Any in-progress apply is abandoned and produces no applied pulse.
- applied and cfg_err are never high in the same cycle.

Test Plan:
1. Reset held 3 cycles, then released. Expected: div_data=8'h05; div_reset_n low for exactly 4 cycles, then high; cfg_ready=1 with enable=1; busy=0.
2. Request 8'h10 in RUN; wrap_in 1->0 20 cycles later. Expected: div_data=8'h10 one cycle after the edge is sampled; div_reset_n low 4 cycles; applied pulses once; no change before the edge.
3. Request 8'h00 with MIN_DIV=1. Expected: cfg_err pulses one cycle later; div_data stays 8'h05; div_reset_n never drops.
4. Request 8'h05 while div_data=8'h05. Expected: applied pulses next cycle; no RESYNC.
5. Request 8'h20 with wrap_in held at 0 and TIMEOUT=16. Expected: forced apply after 16 cycles in WAIT_WRAP; div_data=8'h20; applied pulses 4 cycles later.
6. Request 8'h30, then assert reset during RESYNC. Expected: div_data returns to 8'h05; INIT sequence restarts; no applied pulse; cfg_valid held during WAIT_WRAP is accepted only after return to RUN.
